ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Synchronous FIFO controller that owns the 64x16 dual-port asynchronous-read RAM in the datapath. It converts a valid/ready write stream into the RAM write port (`we`, `address`, `DI`) and drives the RAM's second read address (`DPRA`). It captures `DPO` into a registered first-word-fall-through output stage, so downstream logic sees a clean valid/ready read stream. Total storage is 65 words: 64 in the RAM plus 1 in the output register.

## Interface

- `DW`, 16, data width; must match the RAM word width.
- `AW`, 6, RAM address width; depth is 2^AW = 64.
- `AFULL_THRESH`, 56, `almost_full` asserts when `count` >= this value.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer offers `wr_data`.
- `wr_data`  in  DW  write word.
- `wr_ready`  out  1  controller can accept a word this cycle.
- `rd_valid`  out  1  `rd_data` holds the FIFO head.
- `rd_data`  out  DW  head word (registered).
- `rd_ready`  in  1  consumer takes the head this cycle.
- `count`  out  AW+1  words held: RAM words plus `rd_valid`; range 0..65.
- `empty`  out  1  `count` == 0.
- `almost_full`  out  1  `count` >= `AFULL_THRESH`.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  AW  to RAM `address`; this is the write pointer.
- `ram_di`  out  DW  to RAM `DI`; equals `wr_data`.
- `ram_dpra`  out  AW  to RAM `DPRA`; this is the read pointer.
- `ram_dpo`  in  DW  from RAM `DPO`; combinational read of `ram_dpra`.

## Operation

- **Pointers.** `wptr` and `rptr` are each AW+1 bits; the MSB is the wrap bit.
  - `ram_cnt` = `wptr` − `rptr` (modulo 2^(AW+1)).
  - `ram_full` = (`ram_cnt` == 64).
  - `ram_empty` = (`ram_cnt` == 0).
- **Write side.**
  - `wr_ready` = !`ram_full`. This is combinational from registers only, never from `wr_valid`.
  - `push` = `wr_valid` & `wr_ready`.
  - `ram_we` = `push`.
  - `ram_addr` = `wptr[AW-1:0]`.
  - On `push`, `wptr` increments.
- **Read side.**
  - `ram_dpra` = `rptr[AW-1:0]`.
  - `pop` = `rd_valid` & `rd_ready`.
  - `load` = !`ram_empty` & (!`rd_valid` | `rd_ready`).
  - On `load`: `rd_data` <= `ram_dpo`, `rptr` increments, `rd_valid` <= 1.
  - Else on `pop`: `rd_valid` <= 0, and `rd_data` holds its value.
- **Same-cycle write and read.** A word pushed in cycle N is not loadable in cycle N: `ram_empty` is evaluated from registered pointers, so there is no write-to-read bypass.
- **`count`** = `ram_cnt` + `rd_valid`, registered-derived.
- **`empty`** = !`rd_valid` & `ram_empty`.
- **No data loss or duplication.** Order is strictly preserved across pointer wrap (63→0).
- **Reset (`RST_n` low, any time).**
  - `wptr` = `rptr` = 0.
  - `rd_valid` = 0, `rd_data` = 0.
  - Resulting outputs: `count` = 0, `empty` = 1, `almost_full` = 0, `wr_ready` = 1, `ram_we` = 0 (when `wr_valid` = 0).
  - Contents held mid-operation are discarded. RAM contents are not cleared.
- **Unused RAM port.** `SPO` is not consumed.

## Timing

- **Write-to-read latency.** Word pushed at edge N is stored in RAM at edge N. It is loaded at edge N+1 if the output stage is free, so `rd_valid` is high in cycle N+1 with `rd_data` equal to the word.
- **Throughput.** Sustained throughput is 1 word/cycle each way once non-empty, including with `rd_ready` held high continuously.
- **`wr_ready` deassertion.**
  - `wr_ready` drops the cycle after the push that makes `ram_cnt` = 64.
  - That happens at `count` = 65 if the output stage is occupied.
  - It happens at `count` = 64 only transiently; the next edge loads a word into the output stage and frees a slot.
- **Read while full.** With `ram_full` and `pop` in cycle N, a load occurs in cycle N and `wr_ready` returns in cycle N+1.
- **Handshake rules.**
  - `rd_data` and `rd_valid` are stable while `rd_valid` = 1 and `rd_ready` = 0.
  - `wr_valid` held without `wr_ready` is legal and has no side effect.

## Test plan

- **Reset values.** Release reset → `count` = 0, `empty` = 1, `wr_ready` = 1, `rd_valid` = 0, `rd_data` = 0x0000.
- **Single word.** Push 0xA5A5 at edge 1 with `rd_ready` = 0 → `ram_we` = 1 and `ram_addr` = 0 in the push cycle; `rd_valid` = 1 and `rd_data` = 0xA5A5 after edge 2; `count` = 1 throughout, with `empty` = 0 from edge 1.
- **Fill.** Push 0x0000..0x0040 continuously with no reads → exactly 65 accepted; `wr_ready` = 0; `count` = 65; `almost_full` = 1 from `count` = 56. Then pop one → `rd_data` sequence starts at 0x0000 and `wr_ready` = 1 one cycle later.
- **Wrap and stalls.** Stream 300 words with random `wr_valid`/`rd_ready` → output order exactly matches input; pointers wrap at least 4 times; `count` never exceeds 65.
- **Full streaming.** At `count` = 65, hold `wr_valid` = `rd_ready` = 1 for 20 cycles → `count` oscillates only between 64 and 65; no word lost or repeated.
- **Reset mid-operation.** Assert `RST_n` low at `count` = 30 → outputs return to reset values immediately, without waiting for a clock edge. After release, push 0x1234 → `rd_data` = 0x1234 is the first word out.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a 64x16 async-read dual-port RAM, with a registered
// first-word-fall-through output stage (65 words of total storage).
module ram_fifo_ctrl #(
    parameter int DW           = 16,
    parameter int AW           = 6,
    parameter int AFULL_THRESH = 56
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          almost_full,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_dpra,
    input  logic [DW-1:0] ram_dpo
);

    localparam logic [AW:0] RAM_DEPTH = (AW+1)'(1 << AW);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_THRESH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [AW:0]   ram_cnt;
    logic          ram_full, ram_empty;
    logic          push, pop, load;

    // Pointers carry a wrap bit so 64 stored words is distinguishable from 0.
    assign ram_cnt   = wptr_q - rptr_q;
    assign ram_full  = (ram_cnt == RAM_DEPTH);
    assign ram_empty = (ram_cnt == '0);

    // Handshakes: a word moves on a side only in a cycle where valid and ready
    // are both high; ready never depends on valid, and a stalled head
    // (rd_valid=1, rd_ready=0) keeps rd_data/rd_valid unchanged.
    assign wr_ready = !ram_full;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid_q && rd_ready;
    assign load     = !ram_empty && (!rd_valid_q || rd_ready);

    assign ram_we   = push;
    assign ram_addr = wptr_q[AW-1:0];
    assign ram_di   = wr_data;
    assign ram_dpra = rptr_q[AW-1:0];

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign count       = ram_cnt + {{AW{1'b0}}, rd_valid_q};
    assign empty       = !rd_valid_q && ram_empty;
    assign almost_full = (count >= AFULL_CNT);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        // A word written this cycle is not visible here: ram_empty is registered-derived.
        if (load) begin
            rd_data_d  = ram_dpo;
            rptr_d     = rptr_q + 1'b1;
            rd_valid_d = 1'b1;
        end else if (pop) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl: behavioural RAM model, scoreboard queue of
// accepted words, and hand-computed checks on reset, fill, wrap and streaming.
module tb_ram_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic [6:0]  count;
    logic        empty;
    logic        almost_full;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [15:0] ram_di;
    logic [5:0]  ram_dpra;
    logic [15:0] ram_dpo;

    logic [15:0] mem [64];
    logic [15:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    ram_fifo_ctrl #(.DW(16), .AW(6), .AFULL_THRESH(56)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .count      (count),
        .empty      (empty),
        .almost_full(almost_full),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_dpra   (ram_dpra),
        .ram_dpo    (ram_dpo)
    );

    // clock and RAM model
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    end

    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_di;
    end

    assign ram_dpo = mem[ram_dpra];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: sampled at negedge, describes the transfers of the next edge
    always @(negedge CLK) begin
        if (!RST_n) begin
            exp_q.delete();
        end else begin
            check("count_model", {25'd0, count}, exp_q.size());
            check("empty_model", {31'd0, empty}, {31'd0, exp_q.size() == 0});
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                else check("rd_data_order", {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
            end
            if (wr_valid && wr_ready) exp_q.push_back(wr_data);
        end
    end

    // push incrementing data until count reaches target (rd_ready held low)
    task automatic fill_to(input int target);
        logic acc;
        logic hit;
        bit   done;
        done = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            acc = wr_valid && wr_ready;
            hit = acc && (int'(count) == target - 1);
            @(posedge CLK); #1;
            if (acc) wr_data = wr_data + 16'd1;
            if (hit) done = 1;
        end
        wr_valid = 1'b0;
        if (!done) check("fill_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (empty) done = 1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_acc;
        int  n_push;
        int  max_cnt;
        int  wraps;
        logic acc;
        bit  done;

        RST_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0;
        rd_ready = 1'b0;

        // reset values
        repeat (3) @(posedge CLK);
        #1 RST_n = 1'b1;
        @(negedge CLK);
        check("rst_count",    {25'd0, count}, 32'd0);
        check("rst_empty",    {31'd0, empty}, 32'd1);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data",  {16'd0, rd_data}, 32'h0);
        check("rst_afull",    {31'd0, almost_full}, 32'd0);
        check("rst_ram_we",   {31'd0, ram_we}, 32'd0);

        // single word: push at edge 1, visible at edge 2
        @(posedge CLK); #1;
        wr_valid = 1'b1;
        wr_data  = 16'hA5A5;
        @(negedge CLK);
        check("sw_ram_we",   {31'd0, ram_we}, 32'd1);
        check("sw_ram_addr", {26'd0, ram_addr}, 32'd0);
        check("sw_ram_di",   {16'd0, ram_di}, 32'hA5A5);
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        @(negedge CLK);
        check("sw_count_e1",    {25'd0, count}, 32'd1);
        check("sw_empty_e1",    {31'd0, empty}, 32'd0);
        check("sw_rd_valid_e1", {31'd0, rd_valid}, 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("sw_rd_valid_e2", {31'd0, rd_valid}, 32'd1);
        check("sw_rd_data_e2",  {16'd0, rd_data}, 32'hA5A5);
        check("sw_count_e2",    {25'd0, count}, 32'd1);
        check("sw_dpra_e2",     {26'd0, ram_dpra}, 32'd1);
        drain();

        // fill with 0x0000.. and no reads; held wr_valid beyond full is harmless
        wr_data  = 16'h0;
        wr_valid = 1'b1;
        n_acc    = 0;
        for (int i = 0; i < 75; i++) begin
            @(negedge CLK);
            if (count == 7'd55) check("af_at_55", {31'd0, almost_full}, 32'd0);
            if (count == 7'd56) check("af_at_56", {31'd0, almost_full}, 32'd1);
            acc = wr_valid && wr_ready;
            @(posedge CLK); #1;
            if (acc) begin
                n_acc++;
                wr_data = wr_data + 16'd1;
            end
        end
        wr_valid = 1'b0;
        check("fill_accepted", n_acc, 32'd65);
        @(negedge CLK);
        check("full_count",    {25'd0, count}, 32'd65);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("full_afull",    {31'd0, almost_full}, 32'd1);
        check("full_rd_data",  {16'd0, rd_data}, 32'h0);
        check("full_ram_we",   {31'd0, ram_we}, 32'd0);
        @(posedge CLK); #1;
        rd_ready = 1'b1;
        @(negedge CLK);
        check("pop_cycle_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge CLK); #1;
        rd_ready = 1'b0;
        @(negedge CLK);
        check("after_pop_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("after_pop_count",    {25'd0, count}, 32'd64);
        check("after_pop_rd_data",  {16'd0, rd_data}, 32'h1);
        drain();

        // full streaming: both sides active at count 65
        wr_data = 16'h1000;
        fill_to(65);
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("stream_cnt_range", {31'd0, (count >= 7'd64) && (count <= 7'd65)}, 32'd1);
            acc = wr_valid && wr_ready;
            @(posedge CLK); #1;
            if (acc) wr_data = wr_data + 16'd1;
        end
        wr_valid = 1'b0;
        drain();

        // random stalls across pointer wrap
        n_push  = 0;
        max_cnt = 0;
        wraps   = 0;
        done    = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            wr_valid = (n_push < 300) && ($urandom_range(0, 3) != 0);
            wr_data  = 16'($urandom_range(0, 65535));
            rd_ready = ($urandom_range(0, 2) != 0);
            @(negedge CLK);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (wr_valid && wr_ready) begin
                n_push++;
                if (ram_addr == 6'd63) wraps++;
            end
            if (n_push == 300 && empty) done = 1;
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("rand_done",    {31'd0, done}, 32'd1);
        check("rand_max_cnt", {31'd0, max_cnt <= 65}, 32'd1);
        check("rand_wraps",   {31'd0, wraps >= 4}, 32'd1);

        // asynchronous reset mid-operation
        wr_data = 16'h2000;
        fill_to(30);
        @(negedge CLK);
        check("pre_rst_count", {25'd0, count}, 32'd30);
        @(posedge CLK); #1;
        RST_n = 1'b0;
        #1;
        check("arst_count",    {25'd0, count}, 32'd0);
        check("arst_empty",    {31'd0, empty}, 32'd1);
        check("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("arst_rd_data",  {16'd0, rd_data}, 32'h0);
        check("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("arst_afull",    {31'd0, almost_full}, 32'd0);
        @(posedge CLK); #1;
        RST_n    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge CLK);
            if (rd_valid) done = 1;
        end
        check("post_rst_valid", {31'd0, done}, 32'd1);
        check("post_rst_data",  {16'd0, rd_data}, 32'h1234);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
